// File: rtl/puf_soc_pkg.sv
// puf_soc_pkg
// Shared constants and types for the PUF SoC host-side link controller.
//   REG_BIT_SIZE / FRAM_SIZE : link word width and challenge words per frame
//   RSP_WORDS / TIMEOUT_CYC  : default response length and stall limit
//   NORM_MOD / DEBUG_MOD     : op-mode encodings driven to the SoC
//   puf_state_e              : host controller FSM states
//   cnt_width()              : counter width for a given limit (never below 1)
package puf_soc_pkg;

  localparam int REG_BIT_SIZE = 8;
  localparam int FRAM_SIZE    = 4;
  localparam int RSP_WORDS    = 2;
  localparam int TIMEOUT_CYC  = 1024;

  localparam logic NORM_MOD  = 1'b0;
  localparam logic DEBUG_MOD = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
    WAIT_RSP,
    DONE
  } puf_state_e;

  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/puf_host_wdog.sv
// puf_host_wdog
// Stall counter for the host link. Counts cycles while en is high, saturates
// at LIMIT-1 and flags expired there. clr has priority over en.
//   clk     : clock
//   rst     : asynchronous active-high reset
//   clr     : synchronous clear to zero
//   en      : count this cycle
//   expired : counter sits at LIMIT-1
module puf_host_wdog
  import puf_soc_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int             CW = cnt_width(LIMIT);
  localparam logic [CW-1:0]  TC = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != TC)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == TC);

endmodule

// File: rtl/puf_host_ctrl.sv
// puf_host_ctrl
// Host-side sequencer for one PUF challenge/response exchange with the SoC:
// latches a challenge frame, pulses start, streams the frame out word by word
// (LSW first) over a valid/ready link, then collects RSP_WORDS response words.
// A stall watchdog aborts the exchange if either link direction hangs.
//   clk, rst                    : clock, asynchronous active-high reset
//   i_cmd_valid/mode/chal_data  : command from the host, taken when o_cmd_ready
//   o_cmd_ready, o_busy         : idle / transaction in progress
//   o_start, o_op_mode          : start pulse and op mode to the SoC
//   o_rx_valid/data, i_rx_ready : challenge stream to the SoC
//   i_tx_valid/data, o_tx_ready : response stream from the SoC
//   o_rsp_valid, o_rsp_data     : completion pulse and assembled response
//   o_timeout                   : abort pulse on a stalled link
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | ready for a command
// START    | one-cycle start pulse to the SoC
// SEND     | stream challenge words, word counter selects the word
// WAIT_RSP | accept response words from the SoC
// DONE     | one-cycle response-valid pulse
module puf_host_ctrl
  import puf_soc_pkg::puf_state_e, puf_soc_pkg::IDLE, puf_soc_pkg::START,
         puf_soc_pkg::SEND, puf_soc_pkg::WAIT_RSP, puf_soc_pkg::DONE,
         puf_soc_pkg::NORM_MOD, puf_soc_pkg::cnt_width;
#(
  parameter int REG_BIT_SIZE = puf_soc_pkg::REG_BIT_SIZE,
  parameter int FRAM_SIZE    = puf_soc_pkg::FRAM_SIZE,
  parameter int RSP_WORDS    = puf_soc_pkg::RSP_WORDS,
  parameter int TIMEOUT_CYC  = puf_soc_pkg::TIMEOUT_CYC
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_cmd_valid,
  input  logic                              i_cmd_mode,
  input  logic [FRAM_SIZE*REG_BIT_SIZE-1:0] i_chal_data,
  output logic                              o_cmd_ready,
  output logic                              o_busy,
  output logic                              o_start,
  output logic                              o_op_mode,
  output logic                              o_rx_valid,
  output logic [REG_BIT_SIZE-1:0]           o_rx_data,
  input  logic                              i_rx_ready,
  input  logic                              i_tx_valid,
  input  logic [REG_BIT_SIZE-1:0]           i_tx_data,
  output logic                              o_tx_ready,
  output logic                              o_rsp_valid,
  output logic [RSP_WORDS*REG_BIT_SIZE-1:0] o_rsp_data,
  output logic                              o_timeout
);

  localparam int              WCW    = cnt_width(FRAM_SIZE);
  localparam int              RCW    = cnt_width(RSP_WORDS);
  localparam logic [WCW-1:0]  W_LAST = WCW'(FRAM_SIZE - 1);
  localparam logic [RCW-1:0]  R_LAST = RCW'(RSP_WORDS - 1);

  puf_state_e state, state_nxt;

  logic [FRAM_SIZE-1:0][REG_BIT_SIZE-1:0] chal_q;
  logic [RSP_WORDS-1:0][REG_BIT_SIZE-1:0] rsp_q;
  logic                                   mode_q;
  logic [WCW-1:0]                         wcnt;
  logic [RCW-1:0]                         rcnt;

  logic rx_hs;
  logic tx_hs;
  logic wd_en;
  logic wd_clr;
  logic wd_expired;

  // o_rx_valid is high for all of SEND and o_tx_ready for all of WAIT_RSP,
  // so a handshake reduces to the far side's signal in that state.
  assign rx_hs = (state == SEND) && i_rx_ready;
  assign tx_hs = (state == WAIT_RSP) && i_tx_valid;

  // Count only stalled link cycles; any handshake, any idle state and any
  // state change restart the count so each state sees a fresh window.
  assign wd_en  = ((state == SEND) && !rx_hs) || ((state == WAIT_RSP) && !tx_hs);
  assign wd_clr = !wd_en || (state_nxt != state);

  puf_host_wdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    o_cmd_ready = 1'b0;
    o_busy      = 1'b1;
    o_start     = 1'b0;
    o_op_mode   = mode_q;
    o_rx_valid  = 1'b0;
    o_rx_data   = '0;
    o_tx_ready  = 1'b0;
    o_rsp_valid = 1'b0;
    o_timeout   = 1'b0;
    case (state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        o_op_mode   = NORM_MOD;
        if (i_cmd_valid) state_nxt = START;
      end
      START: begin
        o_start   = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        o_rx_valid = 1'b1;
        o_rx_data  = chal_q[wcnt];
        // a handshake in the limit cycle still counts as progress
        if (rx_hs) begin
          if (wcnt == W_LAST) state_nxt = WAIT_RSP;
        end else if (wd_expired) begin
          o_timeout = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_RSP: begin
        o_tx_ready = 1'b1;
        if (tx_hs) begin
          if (rcnt == R_LAST) state_nxt = DONE;
        end else if (wd_expired) begin
          o_timeout = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        o_rsp_valid = 1'b1;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chal_q <= '0;
      mode_q <= 1'b0;
      wcnt   <= '0;
      rcnt   <= '0;
      rsp_q  <= '0;
    end else begin
      if ((state == IDLE) && i_cmd_valid) begin
        chal_q <= i_chal_data;
        mode_q <= i_cmd_mode;
      end

      if (state_nxt != SEND) begin
        wcnt <= '0;
      end else if (rx_hs && (wcnt != W_LAST)) begin
        wcnt <= wcnt + WCW'(1);
      end

      if (state_nxt != WAIT_RSP) begin
        rcnt <= '0;
      end else if (tx_hs && (rcnt != R_LAST)) begin
        rcnt <= rcnt + RCW'(1);
      end

      // previous response stays visible until the first new word lands
      if (tx_hs) rsp_q[rcnt] <= i_tx_data;
    end
  end

  assign o_rsp_data = rsp_q;

endmodule

// File: tb/tb_puf_host_ctrl.sv
// tb_puf_host_ctrl
// Transaction-level bench for puf_host_ctrl with an accelerated stall limit.
module tb_puf_host_ctrl;

  localparam int W  = 8;
  localparam int NW = 4;
  localparam int NR = 2;
  localparam int TO = 16;

  // {cmd_ready, busy, start, rx_valid, tx_ready, rsp_valid, timeout}
  localparam logic [6:0] C_IDLE  = 7'b1000000;
  localparam logic [6:0] C_START = 7'b0110000;
  localparam logic [6:0] C_SEND  = 7'b0101000;
  localparam logic [6:0] C_WAIT  = 7'b0100100;
  localparam logic [6:0] C_DONE  = 7'b0100010;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_cmd_valid;
  logic              i_cmd_mode;
  logic [NW*W-1:0]   i_chal_data;
  logic              o_cmd_ready;
  logic              o_busy;
  logic              o_start;
  logic              o_op_mode;
  logic              o_rx_valid;
  logic [W-1:0]      o_rx_data;
  logic              i_rx_ready;
  logic              i_tx_valid;
  logic [W-1:0]      i_tx_data;
  logic              o_tx_ready;
  logic              o_rsp_valid;
  logic [NR*W-1:0]   o_rsp_data;
  logic              o_timeout;

  logic [6:0]        ctl;
  logic [NR*W-1:0]   exp_rsp;
  int                n_checks = 0;
  int                n_fail   = 0;

  assign ctl = {o_cmd_ready, o_busy, o_start, o_rx_valid, o_tx_ready, o_rsp_valid, o_timeout};

  always #5 clk = ~clk;

  puf_host_ctrl #(
    .REG_BIT_SIZE (W),
    .FRAM_SIZE    (NW),
    .RSP_WORDS    (NR),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd_mode  (i_cmd_mode),
    .i_chal_data (i_chal_data),
    .o_cmd_ready (o_cmd_ready),
    .o_busy      (o_busy),
    .o_start     (o_start),
    .o_op_mode   (o_op_mode),
    .o_rx_valid  (o_rx_valid),
    .o_rx_data   (o_rx_data),
    .i_rx_ready  (i_rx_ready),
    .i_tx_valid  (i_tx_valid),
    .i_tx_data   (i_tx_data),
    .o_tx_ready  (o_tx_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_timeout   (o_timeout)
  );

  task automatic next_cyc;
    @(posedge clk);
    #2;
  endtask

  // One full exchange. abort: 0 none, 1 stall SEND forever at stall_word,
  // 2 never answer in WAIT_RSP. stall_len forces that many not-ready cycles
  // on stall_word; rnd adds short random stalls on both directions.
  task automatic run_txn(input logic [31:0] chal, input logic mode, input bit rnd,
                         input int stall_word, input int stall_len, input int abort,
                         input logic [15:0] rsp_words);
    logic [7:0] words[$];
    logic       rdy, tv, exp_to;
    int         k, consec, cyc, nrsp;
    for (int i = 0; i < NW; i++) words.push_back(chal[8*i +: 8]);

    i_cmd_valid = 1'b1; i_cmd_mode = mode; i_chal_data = chal; i_rx_ready = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++; $display("FAIL idle_before_cmd: ctl got %b want %b", ctl, C_IDLE);
    end
    next_cyc();
    i_cmd_valid = 1'b0; i_cmd_mode = ~mode; i_chal_data = $urandom;
    #1;
    n_checks++;
    if ({ctl, o_op_mode} !== {C_START, mode}) begin
      n_fail++; $display("FAIL start_pulse: ctl/mode got %b/%b want %b/%b", ctl, o_op_mode, C_START, mode);
    end
    next_cyc();

    k = 0; consec = 0; cyc = 0;
    while (words.size() > 0 && cyc < 64) begin
      if (abort == 1 && k == stall_word)              rdy = 1'b0;
      else if (k == stall_word && consec < stall_len) rdy = 1'b0;
      else if (rnd && consec < 4)                     rdy = ($urandom_range(0, 3) != 0);
      else                                            rdy = 1'b1;
      exp_to = !rdy && (consec == TO - 1);
      i_rx_ready = rdy; i_tx_valid = 1'($urandom_range(0, 1)); i_tx_data = 8'($urandom);
      #1;
      n_checks++;
      if ({ctl, o_op_mode, o_rx_data} !== {C_SEND | 7'(exp_to), mode, words[0]}) begin
        n_fail++;
        $display("FAIL send_word%0d: ctl/mode/data got %b/%b/%h want %b/%b/%h",
                 k, ctl, o_op_mode, o_rx_data, C_SEND | 7'(exp_to), mode, words[0]);
      end
      next_cyc(); cyc++;
      if (exp_to) begin
        i_rx_ready = 1'b0; i_tx_valid = 1'b0;
        #1;
        n_checks++;
        if ({ctl, o_rsp_data} !== {C_IDLE, exp_rsp}) begin
          n_fail++; $display("FAIL after_send_timeout: ctl/rsp got %b/%h want %b/%h", ctl, o_rsp_data, C_IDLE, exp_rsp);
        end
        return;
      end
      if (rdy) begin
        void'(words.pop_front()); k++; consec = 0;
      end else begin
        consec++;
      end
    end
    n_checks++;
    if (words.size() != 0) begin
      n_fail++; $display("FAIL send_budget: words left got %0d want 0", words.size());
      return;
    end

    i_rx_ready = 1'($urandom_range(0, 1));
    nrsp = 0; consec = 0; cyc = 0;
    while (nrsp < NR && cyc < 64) begin
      if (abort == 2)              tv = 1'b0;
      else if (rnd && consec < 4)  tv = ($urandom_range(0, 2) != 0);
      else                         tv = 1'b1;
      exp_to = !tv && (consec == TO - 1);
      i_tx_valid = tv;
      i_tx_data  = tv ? rsp_words[8*nrsp +: 8] : 8'($urandom);
      #1;
      n_checks++;
      if ({ctl, o_op_mode} !== {C_WAIT | 7'(exp_to), mode}) begin
        n_fail++;
        $display("FAIL wait_rsp%0d: ctl/mode got %b/%b want %b/%b", nrsp, ctl, o_op_mode, C_WAIT | 7'(exp_to), mode);
      end
      next_cyc(); cyc++;
      if (exp_to) begin
        i_tx_valid = 1'b0;
        #1;
        n_checks++;
        if ({ctl, o_rsp_data} !== {C_IDLE, exp_rsp}) begin
          n_fail++; $display("FAIL after_wait_timeout: ctl/rsp got %b/%h want %b/%h", ctl, o_rsp_data, C_IDLE, exp_rsp);
        end
        return;
      end
      if (tv) begin
        nrsp++; consec = 0;
      end else begin
        consec++;
      end
    end
    n_checks++;
    if (nrsp != NR) begin
      n_fail++; $display("FAIL wait_budget: words got %0d want %0d", nrsp, NR);
      return;
    end

    i_tx_valid = 1'b0;
    #1;
    n_checks++;
    if ({ctl, o_op_mode, o_rsp_data} !== {C_DONE, mode, rsp_words}) begin
      n_fail++;
      $display("FAIL done: ctl/mode/rsp got %b/%b/%h want %b/%b/%h", ctl, o_op_mode, o_rsp_data, C_DONE, mode, rsp_words);
    end
    exp_rsp = rsp_words;
    next_cyc();
    #1;
    n_checks++;
    if ({ctl, o_rsp_data} !== {C_IDLE, exp_rsp}) begin
      n_fail++; $display("FAIL back_to_idle: ctl/rsp got %b/%h want %b/%h", ctl, o_rsp_data, C_IDLE, exp_rsp);
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_IDLE);
    end
    n_checks++;
    if ({o_rx_data, o_op_mode, o_rsp_data} !== 25'h0) begin
      n_fail++; $display("FAIL reset_data: rx/mode/rsp got %h/%b/%h want 0", o_rx_data, o_op_mode, o_rsp_data);
    end
    next_cyc();
    next_cyc();
    rst = 1'b0;
    next_cyc();
    #1;
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++; $display("FAIL post_reset_ctl: got %b want %b", ctl, C_IDLE);
    end
  endtask

  task automatic test_basic;
    run_txn(32'hA5A5_1234, 1'b0, 1'b0, -1, 0, 0, 16'h015C);
  endtask

  task automatic test_rx_stall;
    run_txn(32'hA5A5_1234, 1'b1, 1'b0, 1, 3, 0, 16'hBEEF);
  endtask

  task automatic test_idle_tx;
    repeat (4) begin
      i_tx_valid = 1'b1; i_tx_data = 8'($urandom);
      #1;
      n_checks++;
      if ({ctl, o_rsp_data} !== {C_IDLE, exp_rsp}) begin
        n_fail++; $display("FAIL idle_tx_ignored: ctl/rsp got %b/%h want %b/%h", ctl, o_rsp_data, C_IDLE, exp_rsp);
      end
      next_cyc();
    end
    i_tx_valid = 1'b0;
  endtask

  task automatic test_timeout_wait;
    run_txn(32'h0BAD_F00D, 1'b1, 1'b0, -1, 0, 2, 16'h0000);
  endtask

  task automatic test_timeout_send;
    run_txn(32'h1357_9BDF, 1'b0, 1'b0, 2, 0, 1, 16'h0000);
  endtask

  task automatic test_hs_wins;
    run_txn(32'h2468_ACE0, 1'b1, 1'b0, 0, TO - 1, 0, 16'h7E81);
  endtask

  task automatic test_reset_mid;
    i_cmd_valid = 1'b1; i_cmd_mode = 1'b1; i_chal_data = 32'h7766_5544; i_rx_ready = 1'b1;
    next_cyc();
    i_cmd_valid = 1'b0;
    next_cyc();
    next_cyc();
    next_cyc();
    i_rx_ready = 1'b0;
    #1;
    n_checks++;
    if ({o_rx_valid, o_rx_data, o_op_mode} !== {1'b1, 8'h66, 1'b1}) begin
      n_fail++; $display("FAIL pre_reset_word2: valid/data/mode got %b/%h/%b want 1/66/1", o_rx_valid, o_rx_data, o_op_mode);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ctl, o_rx_data, o_op_mode, o_rsp_data} !== {C_IDLE, 25'h0}) begin
      n_fail++;
      $display("FAIL mid_reset: ctl/rx/mode/rsp got %b/%h/%b/%h want %b/0/0/0", ctl, o_rx_data, o_op_mode, o_rsp_data, C_IDLE);
    end
    exp_rsp = '0;
    next_cyc();
    rst = 1'b0;
    repeat (3) begin
      next_cyc();
      #1;
      n_checks++;
      if ({ctl, o_rsp_data} !== {C_IDLE, exp_rsp}) begin
        n_fail++; $display("FAIL post_mid_reset_idle: ctl/rsp got %b/%h want %b/%h", ctl, o_rsp_data, C_IDLE, exp_rsp);
      end
    end
    next_cyc();
    run_txn(32'hC0DE_CAFE, 1'b0, 1'b0, -1, 0, 0, 16'h9A3C);
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 20; t++) begin
      run_txn($urandom, 1'($urandom_range(0, 1)), 1'b1, -1, 0, 0, 16'($urandom));
    end
  endtask

  initial begin
    i_cmd_valid = 1'b0; i_cmd_mode = 1'b0; i_chal_data = '0;
    i_rx_ready  = 1'b0; i_tx_valid = 1'b0; i_tx_data   = '0;
    exp_rsp     = '0;
    test_reset();
    test_basic();
    test_rx_stall();
    test_idle_tx();
    test_timeout_wait();
    test_idle_tx();
    test_timeout_send();
    test_hs_wins();
    test_reset_mid();
    test_back_to_back();
    test_idle_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got timeout want finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
